// File: rtl/stopwatch_cmd_arbiter.sv
// Two-requester command arbiter for a stopwatch. It grants one command at a time,
// issues the matching pulse, waits for the status to follow, and reports a result code.
module stopwatch_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid_i,
  input  logic [1:0] a_cmd_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic [1:0] b_cmd_i,
  output logic       b_ready_o,
  input  logic [1:0] sw_status_i,
  output logic       sw_start_o,
  output logic       sw_stop_o,
  output logic       sw_reset_o,
  output logic       rsp_valid_o,
  output logic       rsp_src_o,
  output logic [1:0] rsp_code_o,
  output logic       busy_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: a command transfers in a cycle where valid and ready are both high.
  // Ready is raised only in ARB, for at most one requester, and never during reset.

  typedef enum logic [1:0] {ST_ARB, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  localparam logic [1:0] CMD_ILL   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  localparam logic [1:0] RC_OK      = 2'b00;
  localparam logic [1:0] RC_NOP     = 2'b01;
  localparam logic [1:0] RC_TIMEOUT = 2'b10;
  localparam logic [1:0] RC_ILLEGAL = 2'b11;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] timer_q, timer_d;
  logic       src_q, src_d;
  logic [1:0] cmd_q, cmd_d;
  logic [1:0] code_q, code_d;

  logic       grant_a, grant_b;
  logic [1:0] acc_cmd;
  logic [1:0] acc_target;

  function automatic logic [1:0] target_of(input logic [1:0] c);
    logic [1:0] t;
    t = 2'b00;
    case (c)
      CMD_START: t = 2'b01;
      CMD_STOP:  t = 2'b10;
      default:   t = 2'b00;
    endcase
    return t;
  endfunction

  // A lone reset command beats a non-reset one; ties fall to the round-robin pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_ARB && rst_n) begin
      if (a_valid_i && b_valid_i) begin
        if (a_cmd_i == CMD_RESET && b_cmd_i != CMD_RESET)      grant_a = 1'b1;
        else if (b_cmd_i == CMD_RESET && a_cmd_i != CMD_RESET) grant_b = 1'b1;
        else if (rr_q)                                         grant_b = 1'b1;
        else                                                   grant_a = 1'b1;
      end else if (a_valid_i) begin
        grant_a = 1'b1;
      end else if (b_valid_i) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign acc_cmd    = grant_b ? b_cmd_i : a_cmd_i;
  assign acc_target = target_of(acc_cmd);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    timer_d    = timer_q;
    src_d      = src_q;
    cmd_d      = cmd_q;
    code_d     = code_q;
    sw_start_o = 1'b0;
    sw_stop_o  = 1'b0;
    sw_reset_o = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (grant_a || grant_b) begin
          src_d = grant_b;
          cmd_d = acc_cmd;
          rr_d  = ~grant_b;
          if (acc_cmd == CMD_ILL || (acc_cmd == CMD_STOP && sw_status_i == 2'b00)) begin
            code_d  = RC_ILLEGAL;
            state_d = ST_RESP;
          end else if (sw_status_i == acc_target) begin
            code_d  = RC_NOP;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        sw_start_o = (cmd_q == CMD_START);
        sw_stop_o  = (cmd_q == CMD_STOP);
        sw_reset_o = (cmd_q == CMD_RESET);
        timer_d    = 8'd0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (sw_status_i == target_of(cmd_q)) begin
          code_d  = RC_OK;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TMAX) begin
            code_d  = RC_TIMEOUT;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      rr_q    <= 1'b0;
      timer_q <= 8'd0;
      src_q   <= 1'b0;
      cmd_q   <= 2'b00;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      src_q   <= src_d;
      cmd_q   <= cmd_d;
      code_q  <= code_d;
    end
  end

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_src_o   = rsp_valid_o & src_q;
  assign rsp_code_o  = rsp_valid_o ? code_q : 2'b00;
  assign busy_o      = (state_q != ST_ARB);
  assign dbg_state_o = state_q;

endmodule

// File: doc/stopwatch_cmd_arbiter.md
STOPWATCH_CMD_ARBITER -- requirements
Module: stopwatch_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 15, range 2..255: cycles spent in WAIT before a command is declared timed out.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A (front panel) command valid.
REQ-005 a_cmd  input  2  requester A command code.
REQ-006 a_ready  output  1  requester A command accepted this cycle when a_valid is also high.
REQ-007 b_valid  input  1  requester B (host) command valid.
REQ-008 b_cmd  input  2  requester B command code.
REQ-009 b_ready  output  1  requester B command accepted this cycle when b_valid is also high.
REQ-010 sw_status  input  2  stopwatch status: 00 IDLE, 01 RUNNING, 10 PAUSED; 11 is never a target.
REQ-011 sw_start, sw_stop, sw_reset  output  1 each  single-cycle command pulses to the stopwatch.
REQ-012 rsp_valid  output  1  one-cycle completion strobe.
REQ-013 rsp_src  output  1  requester being answered: 0 = A, 1 = B.
REQ-014 rsp_code  output  2  result code: 00 OK, 01 NOP, 10 TIMEOUT, 11 ILLEGAL.
REQ-015 busy  output  1  high whenever the FSM is not in ARB.

Function
REQ-016 Command codes SHALL be: 01 start (target status 01), 10 stop (target 10), 11 reset (target 00), 00 illegal.
REQ-017 The FSM SHALL have four states: ARB, ISSUE, WAIT, RESP.
REQ-018 Ready outputs SHALL be asserted only in ARB, and at most one of them per cycle, selected combinationally from the valids.
REQ-019 Arbitration when both valids are high: a reset command (11) SHALL win over a non-reset command; otherwise the round-robin pointer SHALL choose.
REQ-020 When exactly one valid is high, that requester SHALL be granted regardless of the pointer.
REQ-021 The round-robin pointer SHALL reset to A and SHALL point to the non-granted requester after every acceptance, including reset-priority grants.
REQ-022 On acceptance (valid and ready) the block SHALL latch src and cmd.
REQ-023 After acceptance the next state SHALL be RESP with ILLEGAL if cmd==00, or if cmd==stop while sw_status==00.
REQ-024 Otherwise, if sw_status already equals the target, the next state SHALL be RESP with NOP.
REQ-025 Otherwise the next state SHALL be ISSUE.
REQ-026 ISSUE SHALL last one cycle, assert exactly the matching sw_* pulse, clear the timer, and go to WAIT.
REQ-027 WAIT: if sw_status equals the target, the FSM SHALL go to RESP with OK.
REQ-028 WAIT: otherwise the timer SHALL increment, and when the timer reaches TIMEOUT_CYC-1 the FSM SHALL go to RESP with TIMEOUT.
REQ-029 A status match SHALL take precedence over timeout in the same cycle.
REQ-030 RESP SHALL last one cycle, drive rsp_valid=1 with the latched src and code, and return to ARB.
REQ-031 rsp_src and rsp_code SHALL read 0 whenever rsp_valid=0.
REQ-032 Latency with a stopwatch whose status updates one cycle after the pulse: acceptance at cycle N, pulse at N+1, rsp_valid (OK) at N+3.
REQ-033 Latency for NOP or ILLEGAL: rsp_valid at N+1, with no sw_* pulse.
REQ-034 At most one sw_* output SHALL be high in any cycle, and none SHALL be high outside ISSUE.
REQ-035 Requester protocol: valid and cmd SHALL be held stable until ready; the block SHALL NOT check this.
REQ-036 Minimum spacing between acceptances SHALL be 2 cycles (ARB then RESP).

Reset
REQ-037 While rst_n=0, the block SHALL immediately force: state=ARB, pointer=A, timer=0, latched src/cmd=0, and all outputs 0 except ready.
REQ-038 While rst_n=0, a_ready and b_ready SHALL also be 0.
REQ-039 Reset asserted during ISSUE or WAIT SHALL abort the command with no response; any sw_* pulse SHALL drop asynchronously.
REQ-040 The first acceptance SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-041 The bench SHALL cover these directed scenarios:
- A start, status 00->01 one cycle after pulse -> a_ready at N, sw_start at N+1, rsp_valid at N+3 with src 0, code 00.
- A and B both valid with start, pointer=A -> A granted first, B granted at the next ARB; responses src 0 then src 1.
- A stop and B reset both valid, pointer=A -> B granted first (reset priority); pointer then points to A.
- B start with status held at 01 -> rsp at N+1 with code 01, no pulse; B stop with status 00 -> code 11.
- A reset with status stuck at 01 and TIMEOUT_CYC=15 -> sw_reset once, rsp code 10 exactly 15 WAIT cycles later, busy low the following cycle.
- rst_n pulled low during WAIT -> all outputs 0 immediately, no rsp_valid; the next A start completes normally.
